// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Latches request pulses from the timer and other sources, masks and
// prioritises them, and raises one IRQ to the CPU together with a 10-bit
// handler vector. It then tracks the in-service state until the CPU signals
// return-from-interrupt. Nesting is not supported.
//
// Priority: bit WIDTH-1 is the highest (the timer pulse line).
// Vector:   (VEC_BASE + sel * VEC_STRIDE) mod 1024.
//
// Optional build macro:
//   IRQ_EDGE_EN  defined   -> a request line pends once per rising edge.
//                undefined -> level capture; a line held high re-pends on
//                             every cycle, including the cycle of its own ack.
//
// Ports:
//   clk         in   1      clock, all state changes on the rising edge
//   reset       in   1      synchronous, active-high reset
//   req         in   WIDTH  request lines (pulses or levels)
//   int_en      in   1      global interrupt enable
//   mask_we     in   1      mask register write enable
//   mask_d      in   WIDTH  mask data, 1 = line enabled
//   ack         in   1      CPU took the vector (honoured only while irq=1)
//   reti        in   1      return from interrupt (honoured only in service)
//   irq         out  1      interrupt request to the CPU (registered)
//   vector      out  10     handler address, stable while irq=1 (registered)
//   pending     out  WIDTH  latched, unserved requests
//   in_service  out  1      handler running (registered)
// ---------------------------------------------------------------------------
module interrupt_controller #(
    parameter int WIDTH      = 8,
    parameter int VEC_BASE   = 1008,
    parameter int VEC_STRIDE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] req,
    input  logic             int_en,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_d,
    input  logic             ack,
    input  logic             reti,
    output logic             irq,
    output logic [9:0]       vector,
    output logic [WIDTH-1:0] pending,
    output logic             in_service
);

    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   cap;
    logic [WIDTH-1:0]   clr;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_d;
    logic [9:0]         vec_calc;
    logic [9:0]         vector_d;
    logic               irq_d;
    logic               in_service_d;

    // -----------------------------------------------------------------------
    // Request capture
    // -----------------------------------------------------------------------
`ifdef IRQ_EDGE_EN
    logic [WIDTH-1:0] req_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= '0;
        end else begin
            req_q <= req;
        end
    end

    assign cap = req & ~req_q;
`else
    assign cap = req;
`endif

    // -----------------------------------------------------------------------
    // Priority encoder: the highest set pending bit wins. Later loop
    // iterations overwrite earlier ones, so the top index survives.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: assign a default before any conditional so no path leaves the
        // variable unassigned; otherwise synthesis infers a latch.
        sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    // Truncation to 10 bits is the intended mod-1024 wrap.
    assign vec_calc = 10'(VEC_BASE + 32'(sel) * VEC_STRIDE);

    // -----------------------------------------------------------------------
    // Next-state and registered-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state;
        sel_d        = sel_q;
        vector_d     = vector;
        irq_d        = irq;
        in_service_d = in_service;
        clr          = '0;

        case (state)
            IDLE: begin
                if (int_en && (|pending)) begin
                    state_d  = REQ;
                    sel_d    = sel;
                    vector_d = vec_calc;
                    irq_d    = 1'b1;
                end
            end

            // Vector and sel_q stay frozen here: a higher-priority arrival
            // waits for the next IDLE pass instead of retargeting the CPU.
            REQ: begin
                if (ack) begin
                    state_d      = SERVICE;
                    clr[sel_q]   = 1'b1;
                    irq_d        = 1'b0;
                    in_service_d = 1'b1;
                end else if (!int_en) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end
            end

            SERVICE: begin
                if (reti) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end

            default: begin
                state_d      = IDLE;
                irq_d        = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sel_q is only meaningful in REQ, but it is reset with the
            // rest so simulation never carries X into the clear logic.
            state      <= IDLE;
            mask       <= '0;
            pending    <= '0;
            sel_q      <= '0;
            vector     <= '0;
            irq        <= 1'b0;
            in_service <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked logic so every register
            // samples the pre-edge values, independent of statement order.
            state      <= state_d;
            sel_q      <= sel_d;
            vector     <= vector_d;
            irq        <= irq_d;
            in_service <= in_service_d;
            // Clear first, then set: a new capture on the bit being
            // acknowledged in the same cycle is kept.
            pending    <= (pending & ~clr) | (cap & mask);
            if (mask_we) begin
                mask <= mask_d;
            end
        end
    end

endmodule
